// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, issues one outstanding
// instruction fetch at a time and presents {pc, insn, valid, fault} to decode.
module if_id_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_fault
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              discard_q, discard_d;
  logic              skid_valid_q, skid_valid_d;
  logic [ILEN-1:0]   skid_data_q, skid_data_d;
  logic              req_valid_q, req_valid_d;
  logic              id_valid_q, id_valid_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic [ILEN-1:0]   id_insn_q, id_insn_d;
  logic              id_fault_q, id_fault_d;

  logic req_fire;
  logic dec_free;
  logic load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      req_valid_q  <= 1'b0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_insn_q    <= NOP_INSN;
      id_fault_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      req_valid_q  <= req_valid_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_insn_q    <= id_insn_d;
      id_fault_q   <= id_fault_d;
    end
  end

  // Next-state, PC, skid and decode-register update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_insn_d    = id_insn_q;
    id_fault_d   = id_fault_q;
    load         = 1'b0;
    req_fire     = (state_q == S_REQ) && req_valid_q && imem_req_ready;
    dec_free     = !id_valid_q || !id_stall;

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      id_valid_d   = 1'b0;
      id_fault_d   = 1'b0;
      id_insn_d    = NOP_INSN;
      skid_valid_d = 1'b0;
      // A request still in flight must have its response dropped.
      if ((state_q == S_WAIT && !imem_rsp_valid) || req_fire) begin
        discard_d = 1'b1;
        state_d   = S_WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (pc_q[1:0] != 2'b00) begin
            if (dec_free) begin
              load       = 1'b1;
              id_valid_d = 1'b1;
              id_fault_d = 1'b1;
              id_pc_d    = pc_q;
              id_insn_d  = NOP_INSN;
              state_d    = S_FAULT;
            end
          end else if (req_fire) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (dec_free) begin
              load       = 1'b1;
              id_valid_d = 1'b1;
              id_fault_d = 1'b0;
              id_pc_d    = pc_q;
              id_insn_d  = imem_rsp_data;
              pc_d       = pc_q + PC_STEP;
              state_d    = S_REQ;
            end else begin
              skid_valid_d = 1'b1;
              skid_data_d  = imem_rsp_data;
              state_d      = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!id_stall && skid_valid_q) begin
            load         = 1'b1;
            id_valid_d   = 1'b1;
            id_fault_d   = 1'b0;
            id_pc_d      = pc_q;
            id_insn_d    = skid_data_q;
            skid_valid_d = 1'b0;
            pc_d         = pc_q + PC_STEP;
            state_d      = S_REQ;
          end
        end
        S_FAULT: load = 1'b1;  // fault stays presented until a redirect
        default: state_d = S_REQ;
      endcase

      if (!load && !id_stall) begin
        id_valid_d = 1'b0;
        id_fault_d = 1'b0;
        id_insn_d  = NOP_INSN;
      end
    end

    req_valid_d = (state_d == S_REQ) && (pc_d[1:0] == 2'b00);
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_instruction = id_insn_q;
  assign id_fault       = id_fault_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage: fetch flow, stall/skid,
// redirect discard, misaligned fault, request back-pressure and reset.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_fault;

  int checks = 0;
  int fails  = 0;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc),
    .id_instruction(id_instruction), .id_fault(id_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    id_stall       = 1'b0;
  endtask

  // Reset then one edge: block sits in S_REQ with a request at RESET_PC.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b0, 64'h8000_0000}) begin
      fails++; $display("FAIL reset_req: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b0, 64'h8000_0000});
    end
    checks++;
    if ({id_valid, id_fault, id_pc, id_instruction} !== {1'b0, 1'b0, 64'h0, 32'h13}) begin
      fails++; $display("FAIL reset_id: got %h expected %h", {id_valid, id_fault, id_pc, id_instruction}, {1'b0, 1'b0, 64'h0, 32'h13});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL release_req_low: got %b expected 0", imem_req_valid);
    end
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0000}) begin
      fails++; $display("FAIL first_req: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0000});
    end
  endtask

  task automatic test_fetch();
    do_reset();
    step();  // handshake at 0x80000000
    checks++;
    if ({imem_req_valid, id_valid} !== 2'b00) begin
      fails++; $display("FAIL fetch_wait0: got %b expected 00", {imem_req_valid, id_valid});
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({id_valid, id_fault, id_pc, id_instruction} !== {1'b1, 1'b0, 64'h8000_0000, 32'h0000_0093}) begin
      fails++; $display("FAIL fetch_insn0: got %h expected %h", {id_valid, id_fault, id_pc, id_instruction}, {1'b1, 1'b0, 64'h8000_0000, 32'h0000_0093});
    end
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0004}) begin
      fails++; $display("FAIL fetch_req1: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0004});
    end
    step();  // handshake at 0x80000004, decode drains to a bubble
    checks++;
    if ({imem_req_valid, id_valid, id_instruction} !== {1'b0, 1'b0, 32'h13}) begin
      fails++; $display("FAIL fetch_bubble: got %h expected %h", {imem_req_valid, id_valid, id_instruction}, {1'b0, 1'b0, 32'h13});
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0113;
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({id_valid, id_fault, id_pc, id_instruction} !== {1'b1, 1'b0, 64'h8000_0004, 32'h0010_0113}) begin
      fails++; $display("FAIL fetch_insn1: got %h expected %h", {id_valid, id_fault, id_pc, id_instruction}, {1'b1, 1'b0, 64'h8000_0004, 32'h0010_0113});
    end
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0008}) begin
      fails++; $display("FAIL fetch_req2: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0008});
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
    step();
    imem_rsp_valid = 1'b0;
    id_stall = 1'b1;
    step();  // stall 1: handshake at 0x80000004
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0113;
    step();  // stall 2: response parked in skid
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req_valid, id_valid, id_pc, id_instruction} !== {1'b0, 1'b1, 64'h8000_0000, 32'h0000_0093}) begin
        fails++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, {imem_req_valid, id_valid, id_pc, id_instruction}, {1'b0, 1'b1, 64'h8000_0000, 32'h0000_0093});
      end
      if (i < 2) step();  // stall cycles 3 and 4
    end
    id_stall = 1'b0;
    step();
    checks++;
    if ({id_valid, id_fault, id_pc, id_instruction} !== {1'b1, 1'b0, 64'h8000_0004, 32'h0010_0113}) begin
      fails++; $display("FAIL skid_release: got %h expected %h", {id_valid, id_fault, id_pc, id_instruction}, {1'b1, 1'b0, 64'h8000_0004, 32'h0010_0113});
    end
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0008}) begin
      fails++; $display("FAIL skid_next_req: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0008});
    end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    step();  // in S_WAIT
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req_valid, id_valid} !== 2'b00) begin
      fails++; $display("FAIL redir_wait: got %b expected 00", {imem_req_valid, id_valid});
    end
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({id_valid, id_instruction} !== {1'b0, 32'h13}) begin
      fails++; $display("FAIL redir_stale_dropped: got %h expected %h", {id_valid, id_instruction}, {1'b0, 32'h13});
    end
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0100}) begin
      fails++; $display("FAIL redir_req: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0100});
    end
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
    step();
    imem_rsp_valid = 1'b0;
    checks++;
    if ({id_valid, id_pc, id_instruction} !== {1'b1, 64'h8000_0100, 32'h0000_0093}) begin
      fails++; $display("FAIL redir_first_insn: got %h expected %h", {id_valid, id_pc, id_instruction}, {1'b1, 64'h8000_0100, 32'h0000_0093});
    end
  endtask

  task automatic test_fault();
    do_reset();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    checks++;
    if ({imem_req_valid, id_valid} !== 2'b00) begin
      fails++; $display("FAIL fault_no_req: got %b expected 00", {imem_req_valid, id_valid});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({imem_req_valid, id_valid, id_fault, id_pc, id_instruction} !== {1'b0, 1'b1, 1'b1, 64'h8000_0102, 32'h13}) begin
        fails++; $display("FAIL fault_present[%0d]: got %h expected %h", i, {imem_req_valid, id_valid, id_fault, id_pc, id_instruction}, {1'b0, 1'b1, 1'b1, 64'h8000_0102, 32'h13});
      end
    end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({id_valid, id_fault, id_instruction} !== {1'b0, 1'b0, 32'h13}) begin
      fails++; $display("FAIL fault_cleared: got %h expected %h", {id_valid, id_fault, id_instruction}, {1'b0, 1'b0, 32'h13});
    end
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0200}) begin
      fails++; $display("FAIL fault_next_req: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0200});
    end
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
    step();
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0004}) begin
        fails++; $display("FAIL ready_low_hold[%0d]: got %h expected %h", i, {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0004});
      end
    end
    imem_req_ready = 1'b1;
    step();  // handshake, now in S_WAIT
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr, id_valid, id_fault, id_pc, id_instruction} !== {1'b0, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 32'h13}) begin
      fails++; $display("FAIL midrun_reset: got %h expected %h", {imem_req_valid, imem_req_addr, id_valid, id_fault, id_pc, id_instruction}, {1'b0, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 32'h13});
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0000}) begin
      fails++; $display("FAIL post_reset_req: got %h expected %h", {imem_req_valid, imem_req_addr}, {1'b1, 64'h8000_0000});
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall_skid();
    test_redirect_discard();
    test_fault();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
